// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared defaults and helpers for the scoreboarded register file
package regfile_sb_pkg;

  localparam int          RF_DEF_DATA_W = 16;
  localparam int          RF_DEF_ADDR_W = 4;
  localparam int unsigned RF_ZERO_ADDR  = 0;

  // True when addr names the hardwired-zero register and that feature is enabled
  function automatic logic rf_is_zero(input int zero_reg, input int unsigned addr);
    return (zero_reg != 0) && (addr == RF_ZERO_ADDR);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/write/scoreboard bus between decode, writeback and the register file
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = RF_DEF_DATA_W,
  parameter int ADDR_W = RF_DEF_ADDR_W
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_addr;
  logic              any_busy;

  modport master (
    output rd_addr_a, rd_addr_b, we, wr_addr, wr_data, busy_set, busy_addr,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, we, wr_addr, wr_data, busy_set, busy_addr,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy
  );
endinterface

// File: rtl/regfile_sb_rf_scoreboard.sv
// rtl/regfile_sb_rf_scoreboard.sv - pending-writeback bit per register with forwarded lookup
module rf_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = RF_DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              busy_set_i,
  input  logic [ADDR_W-1:0] busy_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic              rd_busy_a_o,
  output logic              rd_busy_b_o,
  output logic              any_busy_o
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: a completing write clears, a new issue sets, and set wins on a tie
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      busy_d[i] = (busy_q[i] & ~(we_i && (wr_addr_i == ADDR_W'(i))))
                | (busy_set_i && (busy_addr_i == ADDR_W'(i)));
    end
    if (ZERO_REG != 0) busy_d[RF_ZERO_ADDR] = 1'b0;
  end

  // Busy bits are flops cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Lookups see the forwarded vector so they agree with the data bypass; masked during reset
  assign rd_busy_a_o = rst_n & busy_d[rd_addr_a_i];
  assign rd_busy_b_o = rst_n & busy_d[rd_addr_b_i];
  assign any_busy_o  = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2R1W flop register file with write bypass, zero register and busy scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int              DATA_W    = RF_DEF_DATA_W,
  parameter int              ADDR_W    = RF_DEF_ADDR_W,
  parameter int              ZERO_REG  = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave rf
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_ok;
  logic              byp_en;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;

  // Writes to the hardwired-zero register are dropped; bypass is off while in reset
  assign wr_ok  = rf.we && !rf_is_zero(ZERO_REG, 32'(rf.wr_addr));
  assign byp_en = rst_n && rf.we;

  // Register array: async reset to RESET_VAL, one write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
    end else if (wr_ok) begin
      regs_q[rf.wr_addr] <= rf.wr_data;
    end
  end

  // Port A read: stored value, overridden by same-cycle write data, zero reg forced to 0
  always_comb begin
    rd_data_a = regs_q[rf.rd_addr_a];
    if (byp_en && (rf.wr_addr == rf.rd_addr_a)) rd_data_a = rf.wr_data;
    if (rf_is_zero(ZERO_REG, 32'(rf.rd_addr_a))) rd_data_a = '0;
  end

  // Port B read: same resolution as port A, independently
  always_comb begin
    rd_data_b = regs_q[rf.rd_addr_b];
    if (byp_en && (rf.wr_addr == rf.rd_addr_b)) rd_data_b = rf.wr_data;
    if (rf_is_zero(ZERO_REG, 32'(rf.rd_addr_b))) rd_data_b = '0;
  end

  assign rf.rd_data_a = rd_data_a;
  assign rf.rd_data_b = rd_data_b;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (rf.we),
    .wr_addr_i   (rf.wr_addr),
    .busy_set_i  (rf.busy_set),
    .busy_addr_i (rf.busy_addr),
    .rd_addr_a_i (rf.rd_addr_a),
    .rd_addr_b_i (rf.rd_addr_b),
    .rd_busy_a_o (rf.rd_busy_a),
    .rd_busy_b_o (rf.rd_busy_b),
    .any_busy_o  (rf.any_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed and model-checked bench for regfile_sb
module tb_regfile_sb;

  localparam logic [31:0] RV1 = 32'hA5A5_0001;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) b0 ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) b1 ();

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .RESET_VAL(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .rf(b0.slave)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .RESET_VAL(RV1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rf(b1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    b0.we = 0; b0.wr_addr = 0; b0.wr_data = 0; b0.busy_set = 0; b0.busy_addr = 0;
    b1.we = 0; b1.wr_addr = 0; b1.wr_data = 0; b1.busy_set = 0; b1.busy_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m_regs [16];
  logic [15:0] m_busy;
  logic [15:0] bn;
  logic [31:0] ea, eb;

  initial begin
    rst_n = 0;
    idle();
    b0.rd_addr_a = 5; b0.rd_addr_b = 0;
    b1.rd_addr_a = 0; b1.rd_addr_b = 9;
    tick(); tick();
    #1;
    chk("rst_d0_a", b0.rd_data_a, 32'h0);
    chk("rst_d1_r0", b1.rd_data_a, RV1);
    chk("rst_d1_r9", b1.rd_data_b, RV1);
    chk("rst_any", b0.any_busy, 0);
    rst_n = 1;

    // Test 1: reset asserted in the middle of a write of BEEF to r3
    tick();
    b0.we = 1; b0.wr_addr = 3; b0.wr_data = 16'h1111; b0.busy_set = 1; b0.busy_addr = 4;
    tick();
    idle();
    b0.rd_addr_a = 3; b0.rd_addr_b = 4;
    #1;
    chk("t1_r3_stored", b0.rd_data_a, 32'h1111);
    chk("t1_r4_busy", b0.rd_busy_b, 1);
    chk("t1_any_pre", b0.any_busy, 1);
    b0.we = 1; b0.wr_addr = 3; b0.wr_data = 16'hBEEF; b0.busy_set = 1; b0.busy_addr = 6;
    #1;
    chk("t1_bypass_pre", b0.rd_data_a, 32'hBEEF);
    rst_n = 0;
    #1;
    chk("t1_rst_r3", b0.rd_data_a, 32'h0);
    chk("t1_rst_r4", b0.rd_data_b, 32'h0);
    chk("t1_rst_busy_b", b0.rd_busy_b, 0);
    chk("t1_rst_any", b0.any_busy, 0);
    b0.rd_addr_b = 6;
    #1;
    chk("t1_rst_busyset_masked", b0.rd_busy_b, 0);
    tick();
    chk("t1_rst_edge_r3", b0.rd_data_a, 32'h0);
    chk("t1_rst_edge_any", b0.any_busy, 0);
    idle();
    rst_n = 1;
    #1;
    chk("t1_post_r3", b0.rd_data_a, 32'h0);
    chk("t1_post_busy6", b0.rd_busy_b, 0);
    b0.rd_addr_b = 4;
    #1;
    chk("t1_post_busy4", b0.rd_busy_b, 0);
    chk("t1_post_any", b0.any_busy, 0);

    // Test 2: write r5, bypass on B, stored on A next cycle, then dual-port bypass
    tick();
    b0.we = 1; b0.wr_addr = 5; b0.wr_data = 16'h1234; b0.rd_addr_a = 1; b0.rd_addr_b = 5;
    #1;
    chk("t2_bypass_b", b0.rd_data_b, 32'h1234);
    chk("t2_other_a", b0.rd_data_a, 32'h0);
    tick();
    idle();
    b0.rd_addr_a = 5;
    #1;
    chk("t2_stored_a", b0.rd_data_a, 32'h1234);
    b0.we = 1; b0.wr_addr = 5; b0.wr_data = 16'hABCD;
    #1;
    chk("t2_dual_a", b0.rd_data_a, 32'hABCD);
    chk("t2_dual_b", b0.rd_data_b, 32'hABCD);
    chk("t2_dual_nobusy", b0.rd_busy_a, 0);
    tick();
    idle();
    #1;
    chk("t2_dual_stored", b0.rd_data_a, 32'hABCD);

    // Test 3: zero register ignores writes and busy_set
    b0.we = 1; b0.wr_addr = 0; b0.wr_data = 16'hFFFF; b0.busy_set = 1; b0.busy_addr = 0;
    b0.rd_addr_a = 0; b0.rd_addr_b = 0;
    #1;
    chk("t3_r0_nobypass", b0.rd_data_a, 32'h0);
    chk("t3_r0_nobusy", b0.rd_busy_a, 0);
    tick();
    idle();
    #1;
    chk("t3_r0_data", b0.rd_data_b, 32'h0);
    chk("t3_r0_busy", b0.rd_busy_b, 0);
    chk("t3_any", b0.any_busy, 0);

    // Test 4: busy_set r7, then completing write clears it with bypassed data
    b0.busy_set = 1; b0.busy_addr = 7; b0.rd_addr_a = 7;
    #1;
    chk("t4_fwd_busy", b0.rd_busy_a, 1);
    chk("t4_any_unfwd", b0.any_busy, 0);
    tick();
    idle();
    #1;
    chk("t4_busy_r7", b0.rd_busy_a, 1);
    chk("t4_any", b0.any_busy, 1);
    b0.we = 1; b0.wr_addr = 7; b0.wr_data = 16'h00AA;
    #1;
    chk("t4_clear_fwd", b0.rd_busy_a, 0);
    chk("t4_data_byp", b0.rd_data_a, 32'h00AA);
    chk("t4_any_still", b0.any_busy, 1);
    tick();
    idle();
    #1;
    chk("t4_any_after", b0.any_busy, 0);
    chk("t4_stored", b0.rd_data_a, 32'h00AA);

    // Test 5: set and clear on the same register in one cycle -> set wins
    b0.busy_set = 1; b0.busy_addr = 2; b0.rd_addr_a = 2;
    tick();
    idle();
    b0.we = 1; b0.wr_addr = 2; b0.wr_data = 16'h5555; b0.busy_set = 1; b0.busy_addr = 2;
    #1;
    chk("t5_fwd_busy", b0.rd_busy_a, 1);
    chk("t5_byp_data", b0.rd_data_a, 32'h5555);
    tick();
    idle();
    #1;
    chk("t5_data", b0.rd_data_a, 32'h5555);
    chk("t5_busy", b0.rd_busy_a, 1);
    chk("t5_any", b0.any_busy, 1);

    // Random traffic on the 32-bit, non-zero-reg instance against a reference model
    for (int i = 0; i < 16; i++) m_regs[i] = RV1;
    m_busy = '0;
    for (int n = 0; n < 400; n++) begin
      tick();
      b1.we        = 1'($urandom_range(0, 1));
      b1.wr_addr   = 4'($urandom_range(0, 15));
      b1.wr_data   = $urandom;
      b1.busy_set  = 1'($urandom_range(0, 1));
      b1.busy_addr = 4'($urandom_range(0, 15));
      b1.rd_addr_a = 4'($urandom_range(0, 15));
      b1.rd_addr_b = (n % 4 == 0) ? b1.wr_addr : 4'($urandom_range(0, 15));
      #1;
      bn = m_busy;
      if (b1.we) bn[b1.wr_addr] = 1'b0;
      if (b1.busy_set) bn[b1.busy_addr] = 1'b1;
      ea = (b1.we && b1.wr_addr == b1.rd_addr_a) ? b1.wr_data : m_regs[b1.rd_addr_a];
      eb = (b1.we && b1.wr_addr == b1.rd_addr_b) ? b1.wr_data : m_regs[b1.rd_addr_b];
      chk("rnd_data_a", b1.rd_data_a, ea);
      chk("rnd_data_b", b1.rd_data_b, eb);
      chk("rnd_busy_a", b1.rd_busy_a, bn[b1.rd_addr_a]);
      chk("rnd_busy_b", b1.rd_busy_b, bn[b1.rd_addr_b]);
      chk("rnd_any", b1.any_busy, |m_busy);
      if (b1.we) m_regs[b1.wr_addr] = b1.wr_data;
      m_busy = bn;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
